// File: rtl/mem_system.sv
// Unified memory responder for the multicycle core: word RAM, console FIFO and cycle counter.
// Reads are combinational from pre-edge state; every write completes at the presenting edge.
module mem_system #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ADDR_CON_DATA = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CON_STAT = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CYCLE    = 32'hFFFF_0008;
  localparam logic [PW:0] FULL_CNT      = FIFO_DEPTH[PW:0];

  logic [31:0]   ram_q  [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          err_q, err_d;

  logic [AW-1:0] word_idx_s;
  logic          is_ram_s, is_con_data_s, is_con_stat_s, is_cycle_s, is_mapped_s;
  logic          empty_s, full_s, push_req_s, push_s, pop_s, overflow_s, unmapped_wr_s;
  logic [4:0]    count_ext_s;

  assign word_idx_s    = Address[AW+1:2];
  assign is_ram_s      = (Address[31:AW+2] == '0);
  assign is_con_data_s = (Address == ADDR_CON_DATA);
  assign is_con_stat_s = (Address == ADDR_CON_STAT);
  assign is_cycle_s    = (Address == ADDR_CYCLE);
  assign is_mapped_s   = is_ram_s || is_con_data_s || is_con_stat_s || is_cycle_s;

  assign empty_s       = (count_q == '0);
  assign full_s        = (count_q == FULL_CNT);
  assign pop_s         = !empty_s && tx_ready;
  assign push_req_s    = MemWrite && is_con_data_s;
  // A push into a full FIFO is still accepted when the head leaves at the same edge.
  assign push_s        = push_req_s && (!full_s || pop_s);
  assign overflow_s    = push_req_s && full_s && !pop_s;
  assign unmapped_wr_s = MemWrite && !is_mapped_s;
  assign count_ext_s   = 5'(count_q);

  assign tx_valid = !empty_s;
  assign tx_data  = empty_s ? 8'h00 : fifo_q[rd_ptr_q];
  assign err      = err_q;

  // Read-data mux over RAM and the MMIO registers.
  always_comb begin
    ReadData = 32'h0000_0000;
    if (is_ram_s) begin
      ReadData = ram_q[word_idx_s];
    end else begin
      case (Address)
        ADDR_CON_STAT: ReadData = {24'h00_0000, count_ext_s[3:0], 2'b00, empty_s, full_s};
        ADDR_CYCLE:    ReadData = cycle_q;
        default:       ReadData = 32'h0000_0000;
      endcase
    end
  end

  // Next-state for FIFO bookkeeping, cycle counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cycle_d  = cycle_q + 32'd1;
    err_d    = err_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (MemWrite && is_cycle_s) begin
      cycle_d = WriteData;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end
    if (overflow_s || unmapped_wr_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      err_q    <= err_d;
    end
  end

  // Data storage; contents survive reset and are only meaningful where tracked by the pointers.
  always_ff @(posedge clk) begin
    if (MemWrite && is_ram_s) begin
      ram_q[word_idx_s] <= WriteData;
    end
    if (push_s) begin
      fifo_q[wr_ptr_q] <= WriteData[7:0];
    end
  end
endmodule

// File: tb/tb_mem_system.sv
// Randomized self-checking bench for mem_system against a queue/array reference model,
// plus directed scenarios with hand-computed expectations.
module tb_mem_system;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [31:0] m_ram   [1024];
  bit          m_known [1024];
  logic [7:0]  mq[$];
  logic [31:0] m_cyc;
  bit          m_err;
  logic [31:0] exp_word;
  bit          exp_known;

  mem_system #(.MEM_WORDS(1024), .FIFO_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .Address(Address), .MemWrite(MemWrite),
    .WriteData(WriteData), .ReadData(ReadData), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cyc = 32'd0;
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, output bit known);
    int n;
    n = mq.size();
    known = 1'b1;
    if (a < 32'd4096) begin
      known = m_known[a[11:2]];
      return m_ram[a[11:2]];
    end
    if (a == 32'hFFFF_0004)
      return 32'((n % 16) * 16 + ((n == 0) ? 2 : 0) + ((n == DEPTH) ? 1 : 0));
    if (a == 32'hFFFF_0008) return m_cyc;
    return 32'd0;
  endfunction

  // Applies the effect of one clock edge to the model, using the inputs held at that edge.
  task automatic model_step();
    bit pop;
    bit mapped;
    pop = (mq.size() != 0) && tx_ready;
    if (pop) void'(mq.pop_front());
    mapped = (Address < 32'd4096) || (Address == 32'hFFFF_0000) ||
             (Address == 32'hFFFF_0004) || (Address == 32'hFFFF_0008);
    if (MemWrite && Address == 32'hFFFF_0000) begin
      if (mq.size() < DEPTH) mq.push_back(WriteData[7:0]);
      else m_err = 1'b1;
    end
    if (MemWrite && Address < 32'd4096) begin
      m_ram[Address[11:2]] = WriteData;
      m_known[Address[11:2]] = 1'b1;
    end
    if (MemWrite && Address == 32'hFFFF_0008) m_cyc = WriteData;
    else m_cyc = m_cyc + 32'd1;
    if (MemWrite && !mapped) m_err = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic rdy);
    Address = a;
    MemWrite = we;
    WriteData = wd;
    tx_ready = rdy;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      exp_word = exp_rd(Address, exp_known);
      if (exp_known) chk("ReadData", ReadData, exp_word);
      chk("tx_valid", 32'(tx_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
      chk("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("err", 32'(err), 32'(m_err));
    end
  end

  initial begin
    int sel;
    reset = 1'b1;
    Address = 32'hFFFF_0004;
    MemWrite = 1'b0;
    WriteData = 32'd0;
    tx_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_status", ReadData, 32'h0000_0002);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    check_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // CYCLE five cycles after reset
    drive(32'hFFFF_0008, 1'b0, 32'd0, 1'b0);
    repeat (5) tick();
    chk("cycle_after_rst", ReadData, 32'd5);

    // RAM round trip and out-of-range write
    drive(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0); tick();
    drive(32'h0000_0013, 1'b0, 32'd0, 1'b0);
    chk("ram_rt", ReadData, 32'hDEAD_BEEF);
    tick();
    drive(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0); tick();
    drive(32'h0000_1000, 1'b1, 32'h1234_5678, 1'b0);
    chk("err_before_oob", 32'(err), 32'd0);
    tick();
    drive(32'h0000_0000, 1'b0, 32'd0, 1'b0);
    chk("err_oob", 32'(err), 32'd1);
    chk("ram_unaliased", ReadData, 32'h0000_0000);
    tick();

    // FIFO fill, overflow, drain
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_0000, 1'b1, 32'h41 + i, 1'b0); tick();
    end
    drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b0);
    chk("status_full", ReadData, 32'h0000_0041);
    tick();
    drive(32'hFFFF_0000, 1'b1, 32'h45, 1'b0); tick();
    drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b0);
    chk("err_overflow", 32'(err), 32'd1);
    chk("status_after_drop", ReadData, 32'h0000_0041);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b1);
      chk("drain_data", 32'(tx_data), 32'h41 + i);
      tick();
    end
    chk("drained_valid", 32'(tx_valid), 32'd0);
    chk("drained_status", ReadData, 32'h0000_0002);

    // Push and pop at the same edge while full, then push into empty with ready high
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_0000, 1'b1, 32'h61 + i, 1'b0); tick();
    end
    drive(32'hFFFF_0000, 1'b1, 32'h55, 1'b1); tick();
    drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b0);
    chk("full_pushpop_status", ReadData, 32'h0000_0041);
    chk("full_pushpop_err", 32'(err), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b1);
      chk("pushpop_order", 32'(tx_data), (i == 3) ? 32'h55 : 32'h62 + i);
      tick();
    end
    drive(32'hFFFF_0000, 1'b1, 32'h77, 1'b1);
    chk("empty_push_novalid", 32'(tx_valid), 32'd0);
    tick();
    drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b1);
    chk("empty_push_valid", 32'(tx_valid), 32'd1);
    chk("empty_push_data", 32'(tx_data), 32'h77);
    tick();

    // CYCLE write and wrap
    drive(32'hFFFF_0008, 1'b1, 32'hFFFF_FFFE, 1'b0); tick();
    drive(32'hFFFF_0008, 1'b0, 32'd0, 1'b0);
    chk("cycle_wr", ReadData, 32'hFFFF_FFFE);
    tick();
    chk("cycle_inc", ReadData, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", ReadData, 32'h0000_0000);
    tick();

    // Asynchronous reset with data queued and err set
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'hFFFF_0000, 1'b1, 32'h30 + i, 1'b0); tick();
    end
    drive(32'h2000_0000, 1'b1, 32'h0, 1'b0); tick();
    drive(32'hFFFF_0004, 1'b0, 32'd0, 1'b0);
    chk("pre_rst_err", 32'(err), 32'd1);
    chk("pre_rst_status", ReadData, 32'h0000_0030);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", 32'(tx_valid), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    chk("async_status", ReadData, 32'h0000_0002);
    reset = 1'b0;
    Address = 32'h0000_0010;
    #1;
    chk("ram_survives_rst", ReadData, 32'hDEAD_BEEF);
    tick();

    // Unmapped read
    drive(32'h8000_0000, 1'b0, 32'd0, 1'b0);
    chk("unmapped_rd", ReadData, 32'h0000_0000);
    tick();
    chk("unmapped_rd_err", 32'(err), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: drive({22'd0, 5'($urandom_range(0, 31)), 5'd0} | 32'($urandom_range(0, 3)) |
                             32'({$urandom_range(0, 31), 2'b00}),
                             1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
        5, 6: drive(32'hFFFF_0000, ($urandom_range(0, 2) != 0), $urandom(), 1'($urandom_range(0, 1)));
        7: drive(32'hFFFF_0004, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
        8: drive(32'hFFFF_0008, ($urandom_range(0, 3) == 0), $urandom(), 1'($urandom_range(0, 1)));
        default: drive(($urandom_range(0, 1) != 0) ? 32'h0000_1000 + 32'($urandom_range(0, 4095))
                                                   : 32'h8000_0000 | $urandom(),
                       ($urandom_range(0, 7) == 0), $urandom(), 1'($urandom_range(0, 1)));
      endcase
      tick();
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
